// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
// Imported by the fetch queue top and its slot storage.
package fetch_queue_pkg;

  localparam int unsigned XLEN_P  = 32;
  localparam int unsigned DEPTH_P = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic int unsigned ptr_w(int unsigned d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/fetch_slot_ram.sv
// Slot storage for the fetch queue: pc and instr arrays.
// Independent write ports, asynchronous read at the head slot.
module fetch_slot_ram
  import fetch_queue_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_P,
  parameter int unsigned DEPTH = DEPTH_P,
  localparam int unsigned PW   = ptr_w(DEPTH)
) (
  input  logic            clk_i,
  input  logic            pc_we_i,
  input  logic [PW-1:0]   pc_waddr_i,
  input  logic [XLEN-1:0] pc_wdata_i,
  input  logic            in_we_i,
  input  logic [PW-1:0]   in_waddr_i,
  input  logic [XLEN-1:0] in_wdata_i,
  input  logic [PW-1:0]   raddr_i,
  output logic [XLEN-1:0] rd_pc_o,
  output logic [XLEN-1:0] rd_instr_o
);

  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [XLEN-1:0] in_mem [DEPTH];

  // Contents need no reset; the filled bits qualify them.
  always_ff @(posedge clk_i) begin
    if (pc_we_i) pc_mem[pc_waddr_i] <= pc_wdata_i;
    if (in_we_i) in_mem[in_waddr_i] <= in_wdata_i;
  end

  assign rd_pc_o    = pc_mem[raddr_i];
  assign rd_instr_o = in_mem[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// In-order fetch queue between the PC register, imem and decode.
// Tracks owed responses so a jump redirect can drop stale fetches.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_P,
  parameter int unsigned DEPTH = DEPTH_P
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [XLEN-1:0]          pc_in,
  input  logic                     flush,
  output logic                     pc_stall,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [XLEN-1:0]          imem_rdata,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [XLEN-1:0]          id_pc,
  output logic [XLEN-1:0]          id_instr,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [PW-1:0]    alloc_q, alloc_d;
  logic [PW-1:0]    fill_q, fill_d;
  logic [PW-1:0]    head_q, head_d;
  logic [CW-1:0]    alloc_cnt_q, alloc_cnt_d;
  logic [CW-1:0]    pend_cnt_q, pend_cnt_d;
  logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
  logic [DEPTH-1:0] filled_q, filled_d;

  logic [CW:0] budget;
  logic        grant;
  logic        rsp_drop;
  logic        rsp_fill;
  logic        rsp_old;
  logic        pop;

  // Owed responses for dropped requests still occupy imem capacity.
  assign budget = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};

  assign imem_req  = rst_n & ~flush & (budget < DEPTH_W);
  assign imem_addr = pc_in;
  assign grant     = imem_req & imem_gnt;
  assign pc_stall  = ~grant;

  assign rsp_drop = imem_rvalid & (drop_cnt_q != '0);
  assign rsp_fill = imem_rvalid & (drop_cnt_q == '0)
                  & (pend_cnt_q != '0) & ~flush;
  assign rsp_old  = imem_rvalid
                  & ((drop_cnt_q != '0) | (pend_cnt_q != '0));

  assign id_valid  = filled_q[head_q] & (alloc_cnt_q != '0) & ~flush;
  assign pop       = id_valid & id_ready;
  assign occupancy = alloc_cnt_q;

  // Next-state for pointers, counters and filled bits.
  always_comb begin
    alloc_d     = alloc_q;
    fill_d      = fill_q;
    head_d      = head_q;
    alloc_cnt_d = alloc_cnt_q;
    pend_cnt_d  = pend_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    filled_d    = filled_q;
    if (flush) begin
      alloc_d     = '0;
      fill_d      = '0;
      head_d      = '0;
      alloc_cnt_d = '0;
      pend_cnt_d  = '0;
      filled_d    = '0;
      drop_cnt_d  = drop_cnt_q + pend_cnt_q - CW'(rsp_old);
    end else begin
      if (grant) begin
        filled_d[alloc_q] = 1'b0;
        alloc_d = alloc_q + PW'(1);
      end
      if (rsp_fill) begin
        filled_d[fill_q] = 1'b1;
        fill_d = fill_q + PW'(1);
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d = head_q + PW'(1);
      end
      alloc_cnt_d = alloc_cnt_q + CW'(grant) - CW'(pop);
      pend_cnt_d  = pend_cnt_q + CW'(grant) - CW'(rsp_fill);
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_q     <= '0;
      fill_q      <= '0;
      head_q      <= '0;
      alloc_cnt_q <= '0;
      pend_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      filled_q    <= '0;
    end else begin
      alloc_q     <= alloc_d;
      fill_q      <= fill_d;
      head_q      <= head_d;
      alloc_cnt_q <= alloc_cnt_d;
      pend_cnt_q  <= pend_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      filled_q    <= filled_d;
    end
  end

  fetch_slot_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i      (clk),
    .pc_we_i    (grant),
    .pc_waddr_i (alloc_q),
    .pc_wdata_i (pc_in),
    .in_we_i    (rsp_fill),
    .in_waddr_i (fill_q),
    .in_wdata_i (imem_rdata),
    .raddr_i    (head_q),
    .rd_pc_o    (id_pc),
    .rd_instr_o (id_instr)
  );

  rsp_expected: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (drop_cnt_q != '0) || (pend_cnt_q != '0)
  );

endmodule
